// File: rtl/apb_pkg.sv
`default_nettype none
// ==== apb_pkg : APB bridge state encodings and default bus widths (rev 1.0) ====
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ==== apb_timeout_cnt : saturating ACCESS-phase wait counter (rev 1.0) ====
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] count;

      // Saturates at TIMEOUT so a stalled counter can never wrap back to 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == CW'(TIMEOUT - 1));
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, clear, enable};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ==== apb_master_bridge : single-outstanding valid/ready to APB master (rev 1.0) ====
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_t state;
  state_t state_nxt;
  logic   rdy_en;
  logic   expired;
  logic   accept;

  // Keeps cmd_ready low while reset is asserted and until the first edge after it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = rdy_en;
        if (cmd_valid && rdy_en) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        psel      = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || expired) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = (state == ST_IDLE) && cmd_valid && rdy_en;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (pclk),
    .rst_n   (presetn),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) && !pready),
    .expired (expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // pready takes priority over an expiring timeout on the same cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (state == ST_ACCESS) begin
      if (pready) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (expired) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
